// File: rtl/vga_display_core.sv
// vga_display_core: 640x480@60 VGA timing generator with eight colour bars and a white frame
module vga_display_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk_pix,
    input  logic rst,
    output logic vga_hs,
    output logic vga_vs,
    output logic vga_r,
    output logic vga_g,
    output logic vga_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = $clog2(BAR_W + 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_RIGHT  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_ON    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_BOT    = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_ON    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [BW-1:0] px;
    logic [2:0]    bar;
    logic          h_end;
    logic          visible;
    logic          frame_px;
    logic          hs_next;
    logic          vs_next;
    logic [2:0]    rgb_next;

    // Decode sync and colour from the current counters; bar colour bits are simple inversions of the bar index
    always_comb begin
        h_end    = hcnt == H_LAST;
        visible  = hcnt < H_VIS && vcnt < V_VIS;
        frame_px = hcnt == '0 || hcnt == H_RIGHT || vcnt == '0 || vcnt == V_BOT;
        rgb_next = !visible ? 3'b000 : frame_px ? 3'b111 : {~bar[1], ~bar[2], ~bar[0]};
        hs_next  = !(hcnt >= HS_ON && hcnt < HS_OFF);
        vs_next  = !(vcnt >= VS_ON && vcnt < VS_OFF);
    end

    // Pixel/line counters plus pixel-within-bar and bar counters that replace a divide by BAR_W
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
            px   <= '0;
            bar  <= '0;
        end else begin
            hcnt <= h_end ? '0 : hcnt + 1'b1;
            if (h_end)
                vcnt <= vcnt == V_LAST ? '0 : vcnt + 1'b1;
            px   <= (h_end || px == BAR_LAST) ? '0 : px + 1'b1;
            bar  <= h_end ? '0 : px == BAR_LAST ? bar + 1'b1 : bar;
        end
    end

    // Register the decoded outputs so the pins lag the counters by one clock
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            {vga_r, vga_g, vga_b} <= 3'b000;
        end else begin
            vga_hs <= hs_next;
            vga_vs <= vs_next;
            {vga_r, vga_g, vga_b} <= rgb_next;
        end
    end
endmodule

// File: tb/tb_vga_display_core.sv
// tb_vga_display_core: checks VGA timing and colour bars against a pixel-coordinate model (short vertical timing)
module tb_vga_display_core;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    localparam int NLIT = 13;
    localparam int LIT_E [NLIT] = '{1, 802, 881, 1001, 1161, 1201, 1301, 1401, 1440, 1441, 1600, 4321, 5121};
    localparam int LIT_V [NLIT] = '{7, 7, 6, 3, 5, 4, 1, 0, 7, 0, 0, 7, 0};

    logic clk_pix = 1'b0;
    logic rst = 1'b0;
    logic vga_hs, vga_vs, vga_r, vga_g, vga_b;
    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    int hs_fall = 0, vs_fall = 0, hs_falls = 0, vs_falls = 0;

    vga_display_core #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) vga_display (
        .clk_pix(clk_pix),
        .rst(rst),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b)
    );

    always #5 clk_pix = ~clk_pix;

    // number of rising edges since reset release
    always @(posedge clk_pix or posedge rst)
        if (rst) edges <= 0;
        else edges <= edges + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edges, act, exp);
        end
    endtask

    function automatic logic [2:0] m_rgb(input int x, input int y);
        if (x >= HA || y >= VA) return 3'b000;
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 3'b111;
        return BARS[x / (HA / 8)];
    endfunction

    function automatic logic m_hs(input int x);
        return !(x >= HA + HF && x < HA + HF + HS);
    endfunction

    function automatic logic m_vs(input int y);
        return !(y >= VA + VF && y < VA + VF + VS);
    endfunction

    // every-cycle comparison against the coordinate model, plus literal pins
    always @(negedge clk_pix) begin
        int p, x, y;
        if (rst || edges == 0) begin
            chk("reset_hs", 32'(vga_hs), 1);
            chk("reset_vs", 32'(vga_vs), 1);
            chk("reset_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        end else begin
            p = (edges - 1) % FRAME;
            x = p % HT;
            y = p / HT;
            chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_rgb(x, y)));
            chk("hs", 32'(vga_hs), 32'(m_hs(x)));
            chk("vs", 32'(vga_vs), 32'(m_vs(y)));
            for (int i = 0; i < NLIT; i++)
                if (edges == LIT_E[i]) chk("lit_rgb", 32'({vga_r, vga_g, vga_b}), LIT_V[i]);
        end
    end

    // sync edge timing: first fall, period and low width
    always @(negedge clk_pix) begin
        if (rst) begin
            prev_hs = 1'b1;
            prev_vs = 1'b1;
            hs_falls = 0;
            vs_falls = 0;
        end else begin
            if (prev_hs && !vga_hs) begin
                if (hs_falls == 0) chk("hs_first_fall", edges, 657);
                else chk("hs_period", edges - hs_fall, 800);
                hs_fall = edges;
                hs_falls++;
            end
            if (!prev_hs && vga_hs) chk("hs_low_width", edges - hs_fall, 96);
            if (prev_vs && !vga_vs) begin
                if (vs_falls == 0) chk("vs_first_fall", edges, 6401);
                else chk("vs_period", edges - vs_fall, 10400);
                vs_fall = edges;
                vs_falls++;
            end
            if (!prev_vs && vga_vs) chk("vs_low_width", edges - vs_fall, 1600);
            prev_hs = vga_hs;
            prev_vs = vga_vs;
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_pix);
        rst = 1'b0;
        repeat (3501) @(negedge clk_pix);
        chk("pre_reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'(3'b010));
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_hs", 32'(vga_hs), 1);
        chk("mid_reset_vs", 32'(vga_vs), 1);
        chk("mid_reset_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        repeat (5) @(posedge clk_pix);
        @(negedge clk_pix);
        rst = 1'b0;
        repeat (22900) @(negedge clk_pix);
        chk("hs_fall_count", hs_falls, 28);
        chk("vs_fall_count", vs_falls, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
